// File: rtl/pll_supervisor_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor and reset sequencer.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_e;

  localparam logic [7:0] LOSS_MAX = 8'hFF;

  // The shared counter must hold the longest dwell of any counted state.
  function automatic int cnt_width(input int rst_cycles, input int lock_timeout,
                                   input int settle_cycles, input int release_span);
    int m;
    m = rst_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (settle_cycles > m) m = settle_cycles;
    if (release_span > m) m = release_span;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_supervisor_sync_ff2.sv
// Generic two-flop synchroniser for a single asynchronous bit; both flops load
// RESET_VAL under synchronous active-low reset.
module sync_ff2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_nreset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_supervisor.sv
// PLL lock supervisor: pulses PLL RESETB, waits for a stable lock, then releases
// the downstream reset domains in a staged order; retries failed locks, then faults.
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1200,
  parameter int SETTLE_CYCLES = 120,
  parameter int NUM_STAGES    = 3,
  parameter int STAGE_GAP     = 8,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                  clk_12mhz,
  input  logic                  nreset,
  input  logic                  pll_nlocked,
  input  logic                  relock_req,
  output logic                  pll_resetb,
  output logic [NUM_STAGES-1:0] core_nreset,
  output logic                  fault,
  output logic [7:0]            loss_count,
  output logic [2:0]            state_o
);

  localparam int CNT_W   = cnt_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES,
                                     NUM_STAGES * STAGE_GAP);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [RETRY_W-1:0] retry_t;

  localparam cnt_t   RST_LAST     = cnt_t'(RST_CYCLES - 1);
  localparam cnt_t   TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t   SETTLE_LAST  = cnt_t'(SETTLE_CYCLES - 1);
  localparam cnt_t   RELEASE_LAST = cnt_t'((NUM_STAGES - 1) * STAGE_GAP);
  localparam retry_t RETRY_LIMIT  = retry_t'(MAX_RETRIES);

  logic                  w_nlocked_s;
  logic                  w_lock_s;
  state_e                r_state;
  state_e                w_state_next;
  cnt_t                  r_cnt;
  cnt_t                  w_cnt_next;
  retry_t                r_retry;
  retry_t                w_retry_next;
  logic [7:0]            r_loss;
  logic [7:0]            w_loss_next;
  logic                  r_pll_resetb;
  logic                  r_fault;
  logic [NUM_STAGES-1:0] r_core;
  logic [NUM_STAGES-1:0] w_core_next;

  // Reset value 1 so the block powers up believing the PLL is unlocked.
  sync_ff2 #(
    .RESET_VAL(1'b1)
  ) u_lock_sync (
    .i_clk   (clk_12mhz),
    .i_nreset(nreset),
    .i_d     (pll_nlocked),
    .o_q     (w_nlocked_s)
  );

  assign w_lock_s = ~w_nlocked_s;

  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    w_loss_next  = r_loss;
    case (r_state)
      RST_PLL: begin
        if (r_cnt == RST_LAST) w_state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_next = SETTLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_retry_next = r_retry + retry_t'(1);
          w_state_next = (w_retry_next == RETRY_LIMIT) ? FAULT : RST_PLL;
        end
      end
      SETTLE: begin
        if (!w_lock_s) w_state_next = WAIT_LOCK;
        else if (r_cnt == SETTLE_LAST) w_state_next = RELEASE;
      end
      // Lock loss outranks both stage completion and a concurrent relock request.
      RELEASE, RUN: begin
        if (!w_lock_s) begin
          w_state_next = RST_PLL;
          w_retry_next = '0;
          w_loss_next  = (r_loss == LOSS_MAX) ? r_loss : r_loss + 8'd1;
        end else if ((r_state == RELEASE) && (r_cnt == RELEASE_LAST)) begin
          w_state_next = RUN;
          w_retry_next = '0;
        end else if ((r_state == RUN) && relock_req) begin
          w_state_next = RST_PLL;
          w_retry_next = '0;
        end
      end
      FAULT: begin
        if (relock_req) begin
          w_state_next = RST_PLL;
          w_retry_next = '0;
        end
      end
      default: w_state_next = RST_PLL;
    endcase
  end

  always_comb begin
    w_cnt_next = '0;
    if (w_state_next == r_state) begin
      case (r_state)
        RST_PLL, WAIT_LOCK, SETTLE, RELEASE: w_cnt_next = r_cnt + cnt_t'(1);
        default:                             w_cnt_next = '0;
      endcase
    end
  end

  // Outputs are decoded from the next state so they leave the block glitch-free.
  always_comb begin
    w_core_next = '0;
    if (w_state_next == RUN) begin
      w_core_next = '1;
    end else if (w_state_next == RELEASE) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (w_cnt_next >= cnt_t'(k * STAGE_GAP)) w_core_next[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_12mhz) begin
    if (!nreset) begin
      r_state      <= RST_PLL;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_loss       <= '0;
      r_pll_resetb <= 1'b0;
      r_fault      <= 1'b0;
      r_core       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_retry      <= w_retry_next;
      r_loss       <= w_loss_next;
      r_pll_resetb <= (w_state_next != RST_PLL) && (w_state_next != FAULT);
      r_fault      <= (w_state_next == FAULT);
      r_core       <= w_core_next;
    end
  end

  assign pll_resetb  = r_pll_resetb;
  assign core_nreset = r_core;
  assign fault       = r_fault;
  assign loss_count  = r_loss;
  assign state_o     = r_state;

endmodule

// File: tb/tb_pll_supervisor.sv
// Self-checking bench for pll_supervisor: directed scenarios plus randomized lock
// arrival times checked against a timeline model of the bring-up sequence.
module tb_pll_supervisor;

  localparam int RST      = 4;
  localparam int TO       = 20;
  localparam int SET      = 5;
  localparam int NS       = 3;
  localparam int GAP      = 2;
  localparam int MAXR     = 2;
  localparam int WIN      = RST + TO;
  localparam int SYNC_LAT = 3;

  typedef logic [NS-1:0] core_t;

  logic       clk_12mhz = 1'b0;
  logic       nreset;
  logic       pll_nlocked;
  logic       relock_req;
  logic       pll_resetb;
  core_t      core_nreset;
  logic       fault;
  logic [7:0] loss_count;
  logic [2:0] state_o;

  int num_checks = 0;
  int num_fails  = 0;
  int cyc        = 0;

  pll_supervisor #(
    .RST_CYCLES   (RST),
    .LOCK_TIMEOUT (TO),
    .SETTLE_CYCLES(SET),
    .NUM_STAGES   (NS),
    .STAGE_GAP    (GAP),
    .MAX_RETRIES  (MAXR)
  ) dut (
    .clk_12mhz  (clk_12mhz),
    .nreset     (nreset),
    .pll_nlocked(pll_nlocked),
    .relock_req (relock_req),
    .pll_resetb (pll_resetb),
    .core_nreset(core_nreset),
    .fault      (fault),
    .loss_count (loss_count),
    .state_o    (state_o)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic advanceCycles(input int n);
    repeat (n) begin
      @(posedge clk_12mhz);
      #1;
      cyc++;
    end
  endtask

  // Leaves the bench just after the last reset edge, which is cycle 0.
  task automatic applyReset();
    pll_nlocked = 1'b1;
    relock_req  = 1'b0;
    nreset      = 1'b0;
    advanceCycles(2);
    nreset      = 1'b1;
    cyc         = 0;
  endtask

  // Edge at which SETTLE is entered when nlocked falls RST+d cycles after reset, -1 for FAULT.
  function automatic int settleEdge(input int d);
    int lockEdge;
    int cand;
    lockEdge = RST + d + SYNC_LAT;
    for (int k = 0; k < MAXR; k++) begin
      cand = (lockEdge > k * WIN + RST) ? lockEdge : k * WIN + RST + 1;
      if (cand <= (k + 1) * WIN) return cand;
    end
    return -1;
  endfunction

  function automatic int expState(input int c, input int s);
    if ((s < 0) || (c < s)) begin
      if (c >= MAXR * WIN) return 5;
      return ((c % WIN) < RST) ? 0 : 1;
    end
    if (c < s + SET) return 2;
    if (c < s + SET + (NS - 1) * GAP + 1) return 3;
    return 4;
  endfunction

  function automatic core_t expCore(input int c, input int s);
    int st;
    int n;
    st = expState(c, s);
    if (st == 4) return core_t'((1 << NS) - 1);
    if (st == 3) begin
      n = (c - s - SET) / GAP + 1;
      return core_t'((1 << n) - 1);
    end
    return '0;
  endfunction

  // Nominal bring-up: lock three cycles after RESETB rises, ending in RUN at cycle 20.
  task automatic bringUp();
    applyReset();
    while (cyc < 20) begin
      if (cyc == RST + 3) pll_nlocked = 1'b0;
      advanceCycles(1);
    end
    num_checks++;
    if (state_o !== 3'd4) begin
      num_fails++;
      $display("[TB] FAIL bringup_run: state_o got %0d, want 4", state_o);
    end
  endtask

  task automatic lossCycle();
    pll_nlocked = 1'b1;
    advanceCycles(SYNC_LAT);
    pll_nlocked = 1'b0;
    advanceCycles(15);
  endtask

  task automatic test_reset();
    applyReset();
    num_checks++;
    if ({pll_resetb, core_nreset, fault, loss_count, state_o} !== 15'd0) begin
      num_fails++;
      $display("[TB] FAIL reset_values: got resetb=%b core=%b fault=%b loss=%0d state=%0d, want all zero",
               pll_resetb, core_nreset, fault, loss_count, state_o);
    end
    advanceCycles(RST - 1);
    num_checks++;
    if ({pll_resetb, state_o} !== 4'd0) begin
      num_fails++;
      $display("[TB] FAIL reset_hold: got resetb=%b state=%0d, want 0/0", pll_resetb, state_o);
    end
    advanceCycles(1);
    num_checks++;
    if ({pll_resetb, state_o} !== 4'b1_001) begin
      num_fails++;
      $display("[TB] FAIL reset_exit: got resetb=%b state=%0d, want 1/1", pll_resetb, state_o);
    end
  endtask

  task automatic test_random_bringup();
    int    dlist[7] = '{3, 17, 18, 21, 41, 42, 200};
    int    d;
    int    s;
    int    es;
    core_t ec;
    for (int it = 0; it < 12; it++) begin
      d = (it < 7) ? dlist[it] : int'($urandom_range(45, 0));
      s = settleEdge(d);
      applyReset();
      for (int c = 0; c <= 60; c++) begin
        es = expState(c, s);
        ec = expCore(c, s);
        num_checks++;
        if (state_o !== 3'(es)) begin
          num_fails++;
          $display("[TB] FAIL random_state d=%0d cyc=%0d: got %0d, want %0d", d, c, state_o, es);
        end
        num_checks++;
        if (core_nreset !== ec) begin
          num_fails++;
          $display("[TB] FAIL random_core d=%0d cyc=%0d: got %b, want %b", d, c, core_nreset, ec);
        end
        num_checks++;
        if (pll_resetb !== ((es != 0) && (es != 5))) begin
          num_fails++;
          $display("[TB] FAIL random_resetb d=%0d cyc=%0d: got %b", d, c, pll_resetb);
        end
        num_checks++;
        if (fault !== (es == 5)) begin
          num_fails++;
          $display("[TB] FAIL random_fault d=%0d cyc=%0d: got %b", d, c, fault);
        end
        if (c >= RST + d) pll_nlocked = 1'b0;
        advanceCycles(1);
      end
    end
  endtask

  task automatic test_no_lock();
    applyReset();
    advanceCycles(MAXR * WIN);
    num_checks++;
    if ({state_o, fault, pll_resetb, core_nreset} !== {3'd5, 1'b1, 1'b0, 3'b000}) begin
      num_fails++;
      $display("[TB] FAIL fault_entry: got state=%0d fault=%b resetb=%b core=%b, want 5/1/0/000",
               state_o, fault, pll_resetb, core_nreset);
    end
    advanceCycles(10);
    num_checks++;
    if (state_o !== 3'd5) begin
      num_fails++;
      $display("[TB] FAIL fault_hold: state_o got %0d, want 5", state_o);
    end
    relock_req = 1'b1;
    advanceCycles(1);
    relock_req = 1'b0;
    num_checks++;
    if ({fault, state_o, pll_resetb} !== {1'b0, 3'd0, 1'b0}) begin
      num_fails++;
      $display("[TB] FAIL fault_relock: got fault=%b state=%0d resetb=%b, want 0/0/0",
               fault, state_o, pll_resetb);
    end
    advanceCycles(WIN - 1);
    num_checks++;
    if (state_o !== 3'd1) begin
      num_fails++;
      $display("[TB] FAIL relock_window1: state_o got %0d, want 1", state_o);
    end
    advanceCycles(WIN + 1);
    num_checks++;
    if (state_o !== 3'd5) begin
      num_fails++;
      $display("[TB] FAIL relock_refault: state_o got %0d, want 5", state_o);
    end
  endtask

  task automatic test_glitch();
    int settleAt;
    int glitchAt;
    int dropEdge;
    int releaseAt;
    int es;
    settleAt  = RST + 3 + SYNC_LAT;
    glitchAt  = settleAt + 2;
    dropEdge  = glitchAt + SYNC_LAT;
    releaseAt = dropEdge + 1 + SET;
    applyReset();
    while (cyc < releaseAt) begin
      if (cyc == RST + 3) pll_nlocked = 1'b0;
      if (cyc == glitchAt) pll_nlocked = 1'b1;
      if (cyc == glitchAt + 1) pll_nlocked = 1'b0;
      advanceCycles(1);
      if (cyc > settleAt) begin
        es = (cyc < dropEdge) ? 2 : (cyc == dropEdge) ? 1 : (cyc < releaseAt) ? 2 : 3;
        num_checks++;
        if (state_o !== 3'(es)) begin
          num_fails++;
          $display("[TB] FAIL glitch_state cyc=%0d: got %0d, want %0d", cyc, state_o, es);
        end
        num_checks++;
        if (core_nreset !== ((cyc < releaseAt) ? 3'b000 : 3'b001)) begin
          num_fails++;
          $display("[TB] FAIL glitch_core cyc=%0d: got %b", cyc, core_nreset);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    bringUp();
    advanceCycles(2);
    pll_nlocked = 1'b1;
    advanceCycles(SYNC_LAT - 1);
    num_checks++;
    if (core_nreset !== 3'b111) begin
      num_fails++;
      $display("[TB] FAIL loss_run_hold: core got %b, want 111", core_nreset);
    end
    advanceCycles(1);
    num_checks++;
    if ({core_nreset, state_o, pll_resetb, loss_count} !== {3'b000, 3'd0, 1'b0, 8'd1}) begin
      num_fails++;
      $display("[TB] FAIL loss_run: got core=%b state=%0d resetb=%b loss=%0d, want 000/0/0/1",
               core_nreset, state_o, pll_resetb, loss_count);
    end
    pll_nlocked = 1'b0;
    advanceCycles(10);
    num_checks++;
    if ({core_nreset, state_o} !== {3'b001, 3'd3}) begin
      num_fails++;
      $display("[TB] FAIL loss_rerelease: got core=%b state=%0d, want 001/3", core_nreset, state_o);
    end
    pll_nlocked = 1'b1;
    advanceCycles(2);
    num_checks++;
    if (core_nreset !== 3'b011) begin
      num_fails++;
      $display("[TB] FAIL loss_mid_hold: core got %b, want 011", core_nreset);
    end
    advanceCycles(1);
    num_checks++;
    if ({core_nreset, state_o, loss_count} !== {3'b000, 3'd0, 8'd2}) begin
      num_fails++;
      $display("[TB] FAIL loss_mid: got core=%b state=%0d loss=%0d, want 000/0/2",
               core_nreset, state_o, loss_count);
    end
  endtask

  task automatic test_simultaneous();
    bringUp();
    advanceCycles(2);
    pll_nlocked = 1'b1;
    advanceCycles(SYNC_LAT - 1);
    relock_req = 1'b1;
    advanceCycles(1);
    relock_req = 1'b0;
    num_checks++;
    if ({state_o, core_nreset, loss_count} !== {3'd0, 3'b000, 8'd1}) begin
      num_fails++;
      $display("[TB] FAIL simul_loss_relock: got state=%0d core=%b loss=%0d, want 0/000/1",
               state_o, core_nreset, loss_count);
    end

    bringUp();
    advanceCycles(1);
    relock_req = 1'b1;
    advanceCycles(1);
    relock_req = 1'b0;
    num_checks++;
    if ({state_o, core_nreset, pll_resetb, loss_count} !== {3'd0, 3'b000, 1'b0, 8'd0}) begin
      num_fails++;
      $display("[TB] FAIL relock_run: got state=%0d core=%b resetb=%b loss=%0d, want 0/000/0/0",
               state_o, core_nreset, pll_resetb, loss_count);
    end
    advanceCycles(15);
    num_checks++;
    if ({state_o, core_nreset, loss_count} !== {3'd4, 3'b111, 8'd0}) begin
      num_fails++;
      $display("[TB] FAIL relock_rerun: got state=%0d core=%b loss=%0d, want 4/111/0",
               state_o, core_nreset, loss_count);
    end

    applyReset();
    while (cyc < 11) begin
      if (cyc == RST + 3) pll_nlocked = 1'b0;
      advanceCycles(1);
    end
    relock_req = 1'b1;
    advanceCycles(1);
    relock_req = 1'b0;
    num_checks++;
    if (state_o !== 3'd2) begin
      num_fails++;
      $display("[TB] FAIL relock_settle_ignored: state_o got %0d, want 2", state_o);
    end
    advanceCycles(3);
    num_checks++;
    if ({state_o, core_nreset} !== {3'd3, 3'b001}) begin
      num_fails++;
      $display("[TB] FAIL relock_settle_release: got state=%0d core=%b, want 3/001", state_o, core_nreset);
    end
    advanceCycles(5);
    num_checks++;
    if ({state_o, core_nreset} !== {3'd4, 3'b111}) begin
      num_fails++;
      $display("[TB] FAIL relock_settle_run: got state=%0d core=%b, want 4/111", state_o, core_nreset);
    end
  endtask

  task automatic test_reset_mid();
    bringUp();
    for (int k = 1; k <= 4; k++) begin
      lossCycle();
      num_checks++;
      if ({state_o, loss_count} !== {3'd4, 8'(k)}) begin
        num_fails++;
        $display("[TB] FAIL loss_cycle %0d: got state=%0d loss=%0d, want 4/%0d", k, state_o, loss_count, k);
      end
    end
    pll_nlocked = 1'b1;
    advanceCycles(SYNC_LAT);
    pll_nlocked = 1'b0;
    advanceCycles(11);
    num_checks++;
    if ({state_o, loss_count} !== {3'd3, 8'd5}) begin
      num_fails++;
      $display("[TB] FAIL pre_reset: got state=%0d loss=%0d, want 3/5", state_o, loss_count);
    end
    nreset = 1'b0;
    advanceCycles(1);
    nreset = 1'b1;
    num_checks++;
    if ({pll_resetb, core_nreset, fault, loss_count, state_o} !== 15'd0) begin
      num_fails++;
      $display("[TB] FAIL reset_mid: got resetb=%b core=%b fault=%b loss=%0d state=%0d, want all zero",
               pll_resetb, core_nreset, fault, loss_count, state_o);
    end
  endtask

  task automatic test_saturation();
    int want;
    bringUp();
    for (int k = 1; k <= 256; k++) begin
      lossCycle();
      want = (k > 255) ? 255 : k;
      num_checks++;
      if (loss_count !== 8'(want)) begin
        num_fails++;
        $display("[TB] FAIL loss_saturate k=%0d: got %0d, want %0d", k, loss_count, want);
      end
    end
  endtask

  initial begin
    nreset      = 1'b0;
    pll_nlocked = 1'b1;
    relock_req  = 1'b0;
    test_reset();
    test_random_bringup();
    test_no_lock();
    test_glitch();
    test_lock_loss();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
